ram: RTL and testbench

//   Single-port synchronous 256x32 data RAM for the CPU datapath. One address

---
 rtl/ram.sv | 93 +++++++++
 tb/tb_ram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port 256x32 synchronous data RAM with write-first registered read and a per-word valid map.
// Optional RAM_PARITY_EN adds a stored even-parity bit per word and a registered parity_err output.
module ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              clk,
    input  logic              we,
    output logic [DATA_W-1:0] dout,
    input  logic              rst_n
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_p0;
    logic              rst_sync_p0;
    logic              wr_ok_p1;
    logic              wr_go;

    function automatic logic [DATA_W-1:0] rd_word(input logic v, input logic [DATA_W-1:0] w);
        return v ? w : '0;
    endfunction

    function automatic logic even_par(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    // Reset release is re-timed through two flops; writes stay blocked until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_p0 <= 1'b0;
            wr_ok_p1    <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            wr_ok_p1    <= rst_sync_p0;
        end
    end

    assign wr_go = we && wr_ok_p1;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[addr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p0 <= '0;
        end else if (wr_go) begin
            valid_p0[addr] <= 1'b1;
        end
    end

    // Output stage: write-first, otherwise never-written words read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (wr_go) begin
            dout <= data;
        end else begin
            dout <= rd_word(valid_p0[addr], mem[addr]);
        end
    end

`ifdef RAM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_par[addr] <= even_par(data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (wr_go) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= valid_p0[addr] && (even_par(mem[addr]) != mem_par[addr]);
        end
    end
`endif

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: stimulus pushes expected read data, a monitor pops and compares after each edge.
module tb_ram;

    typedef struct {
        logic [31:0] d;
        logic        p;
        string       name;
    } exp_t;

    logic [7:0]  addr;
    logic [31:0] data;
    logic        clk;
    logic        we;
    logic [31:0] dout;
    logic        rst_n;
`ifdef RAM_PARITY_EN
    logic        parity_err;
`endif

    logic        act;
    exp_t        exp_q[$];
    int          checks;
    int          failures;

    ram dut (
        .addr(addr),
        .data(data),
        .clk(clk),
        .we(we),
        .dout(dout),
        .rst_n(rst_n)
`ifdef RAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i * 3)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every edge with an issued op has one expected response queued.
    always @(posedge clk) begin
        if (act) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=empty want=entry");
            end else begin
                e = exp_q.pop_front();
                chk(e.name, dout, e.d);
`ifdef RAM_PARITY_EN
                chk({e.name, "_par"}, {31'd0, parity_err}, {31'd0, e.p});
`endif
            end
        end
    end

    task automatic op(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] e, input logic pe, input string name);
        exp_t x;
        @(negedge clk);
        we   = w;
        addr = a;
        data = d;
        act  = 1'b1;
        x.d = e;
        x.p = pe;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            act = 1'b0;
            we  = 1'b0;
        end
    endtask

    task automatic drain;
        int guard;
        guard = 0;
        idle(1);
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        act      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        data     = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("reset_dout", dout, 32'h0);
`ifdef RAM_PARITY_EN
        chk("reset_par", {31'd0, parity_err}, 32'h0);
`endif
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // 1: everything reads zero after reset
        for (int i = 0; i < 256; i++) op(1'b0, 8'(i), 32'h0, 32'h0, 1'b0, "rd_after_reset");
        drain();

        // 2: fill with pattern, write-first on each write, then read back
        for (int i = 0; i < 256; i++) op(1'b1, 8'(i), pattern(i), pattern(i), 1'b0, "wr_pattern");
        for (int i = 0; i < 256; i++) op(1'b0, 8'(i), 32'h0, pattern(i), 1'b0, "rd_pattern");
        drain();

        // 3: write-first, then read-after-write
        op(1'b1, 8'h5A, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr_first_5A");
        op(1'b0, 8'h5A, 32'h0, 32'hDEADBEEF, 1'b0, "raw_5A");
        // 4: back-to-back writes to the same word
        op(1'b1, 8'h10, 32'h1, 32'h1, 1'b0, "wr1_10");
        op(1'b1, 8'h10, 32'h2, 32'h2, 1'b0, "wr2_10");
        op(1'b0, 8'h10, 32'h0, 32'h2, 1'b0, "rd_10");
        op(1'b0, 8'h11, 32'h0, pattern(17), 1'b0, "rd_11_neighbour");
        op(1'b0, 8'hFF, 32'h0, pattern(255), 1'b0, "rd_FF_top");
        drain();

`ifdef RAM_PARITY_EN
        // 6: corrupt a stored bit, parity must flag it; clean word must not
        op(1'b1, 8'h33, 32'h12345678, 32'h12345678, 1'b0, "wr_33");
        drain();
        dut.mem[8'h33][5] = ~dut.mem[8'h33][5];
        op(1'b0, 8'h33, 32'h0, 32'h12345658, 1'b1, "rd_33_corrupt");
        op(1'b0, 8'h34, 32'h0, pattern(52), 1'b0, "rd_34_clean");
        drain();
`endif

        // 5: asynchronous reset mid-cycle clears dout at once; write under reset is discarded
        @(negedge clk);
        op(1'b0, 8'h20, 32'h0, pattern(32), 1'b0, "rd_20_prereset");
        drain();
        #2 rst_n = 1'b0;
        #1;
        chk("midcycle_reset_dout", dout, 32'h0);
        op(1'b1, 8'h77, 32'hCAFEF00D, 32'h0, 1'b0, "wr_during_reset");
        idle(2);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 256; i++) op(1'b0, 8'(i), 32'h0, 32'h0, 1'b0, "rd_after_midreset");
        drain();
        op(1'b1, 8'h77, 32'h00C0FFEE, 32'h00C0FFEE, 1'b0, "wr_77_post");
        op(1'b0, 8'h77, 32'h0, 32'h00C0FFEE, 1'b0, "rd_77_post");
        op(1'b0, 8'h78, 32'h0, 32'h0, 1'b0, "rd_78_still_zero");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
